pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath and the pipe_ctrl hazard/stall controller.
// The master drives the pipeline status; the slave (pipe_ctrl) returns the stall/flush/redirect controls.
interface pipe_ctrl_if;
  logic        jump_en_i;
  logic [3:0]  jump_addr_i;
  logic [2:0]  id_rs1_addr_i;
  logic [2:0]  id_rs2_addr_i;
  logic        id_rs1_ren_i;
  logic        id_rs2_ren_i;
  logic [2:0]  ex_rd_addr_i;
  logic        ex_reg_wen_i;
  logic        ex_is_load_i;
  logic        mul_start_i;
  logic        mul_done_i;
  logic        halt_i;
  logic        resume_i;

  logic [3:0]  stall_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        jump_en_o;
  logic [3:0]  jump_addr_o;
  logic        busy_o;
  logic        err_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  modport master (
    output jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_ren_i, id_rs2_ren_i, ex_rd_addr_i, ex_reg_wen_i,
           ex_is_load_i, mul_start_i, mul_done_i, halt_i, resume_i,
    input  stall_o, flush_if_id_o, flush_id_ex_o, jump_en_o, jump_addr_o,
           busy_o, err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i,
           id_rs1_ren_i, id_rs2_ren_i, ex_rd_addr_i, ex_reg_wen_i,
           ex_is_load_i, mul_start_i, mul_done_i, halt_i, resume_i,
    output stall_o, flush_if_id_o, flush_id_ex_o, jump_en_o, jump_addr_o,
           busy_o, err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump redirect/flush, load-use stall, multi-cycle unit wait
// with timeout, debug halt, and saturating stall/flush performance counters.
module pipe_ctrl (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RUN, MUL_BUSY, HALT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic [3:0]  stall;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        jump_en;
  logic [3:0]  jump_addr;
  logic        busy;
  logic        load_use;

  assign load_use = bus.ex_is_load_i && bus.ex_reg_wen_i && (bus.ex_rd_addr_i != 3'd0) &&
                    ((bus.id_rs1_ren_i && (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) ||
                     (bus.id_rs2_ren_i && (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    stall       = 4'b0000;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 4'h0;
    busy        = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.jump_en_i) begin
          // A taken jump wins: it squashes the load-use stall and any mul_start/halt request.
          jump_en     = 1'b1;
          jump_addr   = bus.jump_addr_i;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else begin
          if (load_use) begin
            stall       = 4'b0011;
            flush_id_ex = 1'b1;
          end
          if (bus.mul_start_i) begin
            state_d = MUL_BUSY;
            tmo_d   = 8'd0;
          end else if (bus.halt_i) begin
            state_d = HALT;
          end
        end
      end

      MUL_BUSY: begin
        busy = 1'b1;
        if (bus.mul_done_i) begin
          state_d = RUN;
        end else begin
          stall = 4'b1111;
          tmo_d = tmo_q + 8'd1;
          // The 255th waiting cycle gives up on the unit and flags the timeout.
          if (tmo_q == 8'd254) begin
            state_d = RUN;
            err_d   = 1'b1;
          end
        end
      end

      HALT: begin
        busy = 1'b1;
        if (bus.resume_i) state_d = RUN;
        else              stall   = 4'b1111;
      end

      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((stall != 4'b0000) && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    flush_cnt_d = flush_cnt_q;
    if ((flush_if_id || flush_id_ex) && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q     <= RUN;
      tmo_q       <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs are forced quiet for the whole time reset is held, whatever state was left behind.
  assign bus.stall_o       = rst ? 4'b0000 : stall;
  assign bus.flush_if_id_o = rst ? 1'b0    : flush_if_id;
  assign bus.flush_id_ex_o = rst ? 1'b0    : flush_id_ex;
  assign bus.jump_en_o     = rst ? 1'b0    : jump_en;
  assign bus.jump_addr_o   = rst ? 4'h0    : jump_addr;
  assign bus.busy_o        = rst ? 1'b0    : busy;
  assign bus.err_o         = rst ? 1'b0    : err_q;
  assign bus.stall_cnt_o   = rst ? 16'd0   : stall_cnt_q;
  assign bus.flush_cnt_o   = rst ? 16'd0   : flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: hazards, jump priority, mul wait/timeout, halt and reset.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   nstall;

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.jump_en_i     = 1'b0;
    bus.jump_addr_i   = 4'h0;
    bus.id_rs1_addr_i = 3'd0;
    bus.id_rs2_addr_i = 3'd0;
    bus.id_rs1_ren_i  = 1'b0;
    bus.id_rs2_ren_i  = 1'b0;
    bus.ex_rd_addr_i  = 3'd0;
    bus.ex_reg_wen_i  = 1'b0;
    bus.ex_is_load_i  = 1'b0;
    bus.mul_start_i   = 1'b0;
    bus.mul_done_i    = 1'b0;
    bus.halt_i        = 1'b0;
    bus.resume_i      = 1'b0;
  endtask

  // Load in EX writing rd, ID reading rs1=5 and rs2 (both enabled).
  task automatic set_hazard(input logic [2:0] rd, input logic [2:0] rs2);
    bus.ex_is_load_i  = 1'b1;
    bus.ex_reg_wen_i  = 1'b1;
    bus.ex_rd_addr_i  = rd;
    bus.id_rs1_addr_i = 3'd5;
    bus.id_rs1_ren_i  = 1'b1;
    bus.id_rs2_addr_i = rs2;
    bus.id_rs2_ren_i  = 1'b1;
  endtask

  // Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();

    // Reset held with active requests: everything must read 0.
    rst = 1'b1;
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 4'hA; bus.halt_i = 1'b1;
    @(negedge clk);
    check("rst_stall",     bus.stall_o, 4'h0);
    check("rst_jump_en",   bus.jump_en_o, 1'b0);
    check("rst_jump_addr", bus.jump_addr_o, 4'h0);
    check("rst_flush",     {bus.flush_if_id_o, bus.flush_id_ex_o}, 2'b00);
    check("rst_busy",      bus.busy_o, 1'b0);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("post_rst_busy",   bus.busy_o, 1'b0);
    check("post_rst_err",    bus.err_o, 1'b0);
    check("post_rst_scnt",   bus.stall_cnt_o, 16'd0);
    check("post_rst_fcnt",   bus.flush_cnt_o, 16'd0);
    check("post_rst_jaddr",  bus.jump_addr_o, 4'h0);

    // Load-use on rs2: one-cycle 0011 stall with ID/EX bubble.
    next_cycle();
    set_hazard(3'd3, 3'd3);
    @(negedge clk);
    check("lu_stall",    bus.stall_o, 4'b0011);
    check("lu_flush_ie", bus.flush_id_ex_o, 1'b1);
    check("lu_flush_ii", bus.flush_if_id_o, 1'b0);
    check("lu_jump_en",  bus.jump_en_o, 1'b0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("lu_release",  bus.stall_o, 4'b0000);
    check("lu_scnt",     bus.stall_cnt_o, 16'd1);
    check("lu_fcnt",     bus.flush_cnt_o, 16'd1);

    // Same pattern with rd=x0: no hazard.
    next_cycle();
    set_hazard(3'd0, 3'd0);
    @(negedge clk);
    check("x0_stall", bus.stall_o, 4'b0000);
    check("x0_flush", bus.flush_id_ex_o, 1'b0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("x0_scnt", bus.stall_cnt_o, 16'd1);

    // Jump together with a hazard and mul_start: jump wins, FSM stays in RUN.
    next_cycle();
    set_hazard(3'd3, 3'd3);
    bus.jump_en_i = 1'b1; bus.jump_addr_i = 4'hA; bus.mul_start_i = 1'b1;
    @(negedge clk);
    check("jmp_en",    bus.jump_en_o, 1'b1);
    check("jmp_addr",  bus.jump_addr_o, 4'hA);
    check("jmp_flush", {bus.flush_if_id_o, bus.flush_id_ex_o}, 2'b11);
    check("jmp_stall", bus.stall_o, 4'b0000);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("jmp_busy",  bus.busy_o, 1'b0);
    check("jmp_fcnt",  bus.flush_cnt_o, 16'd2);
    check("jmp_scnt",  bus.stall_cnt_o, 16'd1);

    // mul_start then done after 5 waiting cycles.
    next_cycle();
    bus.mul_start_i = 1'b1;
    @(negedge clk);
    check("mul_start_stall", bus.stall_o, 4'b0000);
    next_cycle();
    bus.mul_start_i = 1'b0;
    nstall = 0;
    for (int i = 0; i < 5; i++) begin
      bus.jump_en_i = (i == 2);
      @(negedge clk);
      if (bus.stall_o == 4'b1111 && bus.busy_o && !bus.jump_en_o &&
          !bus.flush_if_id_o && !bus.flush_id_ex_o) nstall++;
      next_cycle();
    end
    bus.jump_en_i = 1'b0;
    check("mul_wait_cycles", nstall, 5);
    bus.mul_done_i = 1'b1;
    @(negedge clk);
    check("mul_done_stall", bus.stall_o, 4'b0000);
    check("mul_done_busy",  bus.busy_o, 1'b1);
    next_cycle();
    bus.mul_done_i = 1'b0;
    @(negedge clk);
    check("mul_after_busy", bus.busy_o, 1'b0);
    check("mul_after_err",  bus.err_o, 1'b0);
    check("mul_scnt",       bus.stall_cnt_o, 16'd6);

    // mul_start with no done: 255 stall cycles, then RUN with sticky err.
    next_cycle();
    bus.mul_start_i = 1'b1;
    next_cycle();
    bus.mul_start_i = 1'b0;
    nstall = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (bus.stall_o == 4'b1111 && bus.busy_o) nstall++;
      next_cycle();
    end
    check("tmo_cycles", nstall, 255);
    @(negedge clk);
    check("tmo_busy",  bus.busy_o, 1'b0);
    check("tmo_stall", bus.stall_o, 4'b0000);
    check("tmo_err",   bus.err_o, 1'b1);
    check("tmo_scnt",  bus.stall_cnt_o, 16'd261);
    next_cycle();
    @(negedge clk);
    check("tmo_err_sticky", bus.err_o, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("tmo_rst_err", bus.err_o, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("tmo_cleared_err",  bus.err_o, 1'b0);
    check("tmo_cleared_scnt", bus.stall_cnt_o, 16'd0);

    // Halt then resume.
    next_cycle();
    bus.halt_i = 1'b1;
    @(negedge clk);
    check("halt_req_stall", bus.stall_o, 4'b0000);
    next_cycle();
    bus.halt_i = 1'b0;
    @(negedge clk);
    check("halt_stall", bus.stall_o, 4'b1111);
    check("halt_busy",  bus.busy_o, 1'b1);
    next_cycle();
    bus.resume_i = 1'b1;
    @(negedge clk);
    check("resume_stall", bus.stall_o, 4'b0000);
    check("resume_busy",  bus.busy_o, 1'b1);
    next_cycle();
    bus.resume_i = 1'b0;
    @(negedge clk);
    check("resumed_busy", bus.busy_o, 1'b0);
    check("resumed_scnt", bus.stall_cnt_o, 16'd1);

    // Halt again, then reset mid-HALT.
    next_cycle();
    bus.halt_i = 1'b1;
    next_cycle();
    bus.halt_i = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("hrst_stall", bus.stall_o, 4'b0000);
    check("hrst_busy",  bus.busy_o, 1'b0);
    check("hrst_scnt",  bus.stall_cnt_o, 16'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("hrst_run_busy",  bus.busy_o, 1'b0);
    check("hrst_run_stall", bus.stall_o, 4'b0000);
    check("hrst_run_scnt",  bus.stall_cnt_o, 16'd0);
    check("hrst_run_fcnt",  bus.flush_cnt_o, 16'd0);
    next_cycle();
    set_hazard(3'd3, 3'd3);
    @(negedge clk);
    check("hrst_run_hazard", bus.stall_o, 4'b0011);
    next_cycle();
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
